// File: rtl/lut_sched_pkg.sv
// Shared definitions for the LUT layer scheduler.
//
// Contents:
//   state_t      - scheduler FSM states {IDLE, RUN, LAST, OUT}
//   table_depth  - number of table entries for a layer (neurons << input bits)
//   DEFAULT_*    - default layer geometry and the matching table depth
package lut_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // waiting for a vector; config writes allowed
        RUN  = 2'd1,  // issuing one table read per neuron
        LAST = 2'd2,  // draining the final read
        OUT  = 2'd3   // presenting the result until downstream takes it
    } state_t;

    // Every neuron owns a contiguous block of 2^in_bits entries.
    function automatic int table_depth(input int num_neurons, input int in_bits);
        return num_neurons << in_bits;
    endfunction

    localparam int DEFAULT_NUM_NEURONS = 32;
    localparam int DEFAULT_IN_BITS     = 8;
    localparam int DEFAULT_OUT_BITS    = 2;
    localparam int DEFAULT_TABLE_DEPTH = table_depth(DEFAULT_NUM_NEURONS, DEFAULT_IN_BITS);

endpackage

// File: rtl/lut_table_ram.sv
// Shared truth-table memory for all neurons of a layer.
// Single port: one address is used for both the write and the read.
// Read-before-write, synchronous read with one cycle of latency.
//
// Ports:
//   clk    in   clock
//   we     in   write strobe
//   addr   in   entry address {neuron_idx, input_pattern}
//   wdata  in   entry value to write
//   rdata  out  entry value at the previous cycle's address
module lut_table_ram #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: no reset here on purpose: a reset port would stop the tools from
    // mapping this onto RAM, and the table must survive a scheduler reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed LogicNets layer: one shared truth-table RAM serves every
// neuron, one lookup per neuron per cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     input vector handshake
//   s_data              packed inputs, neuron n at [n*IN_BITS +: IN_BITS]
//   m_valid/m_ready     output vector handshake
//   m_data              packed outputs, neuron n at [n*OUT_BITS +: OUT_BITS]
//   cfg_we/cfg_addr     table write strobe and address {neuron_idx, pattern}
//   cfg_wdata           table entry value
//   cfg_busy            high outside IDLE; writes are dropped while high
//
// Timing: acceptance edge = cycle 0, reads issued in cycles 1..NUM_NEURONS,
// final read drained in LAST, m_valid high from cycle NUM_NEURONS+2.
module lut_layer_scheduler
    import lut_sched_pkg::*;
#(
    parameter  int NUM_NEURONS = DEFAULT_NUM_NEURONS,
    parameter  int IN_BITS     = DEFAULT_IN_BITS,
    parameter  int OUT_BITS    = DEFAULT_OUT_BITS,
    localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NUM_NEURONS*IN_BITS-1:0]  s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_NEURONS*OUT_BITS-1:0] m_data,
    input  logic                            cfg_we,
    input  logic [IDX_W+IN_BITS-1:0]        cfg_addr,
    input  logic [OUT_BITS-1:0]             cfg_wdata,
    output logic                            cfg_busy
);

    localparam int DEPTH = table_depth(NUM_NEURONS, IN_BITS);

    state_t                         state;
    logic [IDX_W-1:0]               cnt;       // neuron whose read is issued this cycle
    logic [IDX_W-1:0]               rd_idx;    // neuron whose read data arrives this cycle
    logic                           rd_pend;   // ram_rdata holds a valid lookup this cycle
    logic [NUM_NEURONS*IN_BITS-1:0] in_reg;

    logic [IN_BITS-1:0]             cur_pattern;
    logic [IDX_W+IN_BITS-1:0]       ram_addr;
    logic                           ram_we;
    logic [OUT_BITS-1:0]            ram_rdata;

    assign cur_pattern = in_reg[int'(cnt)*IN_BITS +: IN_BITS];

    // The single RAM port belongs to the config interface except while a
    // vector is being scheduled.
    assign ram_addr = (state == RUN) ? {cnt, cur_pattern} : cfg_addr;
    assign ram_we   = cfg_we && (state == IDLE);

    // A config write wins over input acceptance in the same IDLE cycle.
    assign s_ready  = (state == IDLE) && !cfg_we;
    assign cfg_busy = (state != IDLE);

    lut_table_ram #(
        .DATA_W (OUT_BITS),
        .ADDR_W (IDX_W + IN_BITS),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (cfg_wdata),
        .rdata (ram_rdata)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rd_idx  <= '0;
            rd_pend <= 1'b0;
            in_reg  <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            // Read data trails its address by one cycle; remember which
            // neuron the address belonged to so the result lands in its slice.
            rd_pend <= (state == RUN);
            rd_idx  <= cnt;
            if (rd_pend) begin
                m_data[int'(rd_idx)*OUT_BITS +: OUT_BITS] <= ram_rdata;
            end

            case (state)
                IDLE: begin
                    if (s_valid && s_ready) begin
                        in_reg <= s_data;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // Terminal compare rather than counter wrap, so a
                    // non-power-of-2 layer never issues an out-of-range neuron.
                    if (cnt == IDX_W'(NUM_NEURONS - 1)) begin
                        state <= LAST;
                    end
                end
                LAST: begin
                    m_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Self-checking bench for lut_layer_scheduler (default geometry).
// Stimulus pushes the expected output vector and its acceptance cycle into a
// scoreboard; an independent monitor pops and compares when m_valid rises.
module tb_lut_layer_scheduler;

    localparam int N   = 32;
    localparam int IB  = 8;
    localparam int OB  = 2;
    localparam int IW  = 5;
    localparam int SW  = N * IB;
    localparam int MW  = N * OB;
    localparam int LAT = N + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [SW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [MW-1:0] m_data;
    logic          cfg_we = 1'b0;
    logic [IW+IB-1:0] cfg_addr = '0;
    logic [OB-1:0] cfg_wdata = '0;
    logic          cfg_busy;

    lut_layer_scheduler #(
        .NUM_NEURONS (N),
        .IN_BITS     (IB),
        .OUT_BITS    (OB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_busy  (cfg_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [MW-1:0] exp_q[$];
    int            acc_q[$];
    int            hs_edge = -1;   // edge at which the last output handshake happened

    logic [OB-1:0] tbl [N][1 << IB];   // bench model of the table contents

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Input vector with slice n = n: the basic-lookup pattern.
    function automatic logic [SW-1:0] vec_index();
        logic [SW-1:0] v = '0;
        for (int n = 0; n < N; n++) v[n*IB +: IB] = IB'(n);
        return v;
    endfunction

    // Hand-derived result of the basic pattern with table (n+x)&3: (2n)&3.
    function automatic logic [MW-1:0] exp_basic();
        logic [MW-1:0] v = '0;
        for (int n = 0; n < N; n++) v[n*OB +: OB] = OB'((2 * n) & 3);
        return v;
    endfunction

    function automatic logic [MW-1:0] exp_model(input logic [SW-1:0] d);
        logic [MW-1:0] v = '0;
        for (int n = 0; n < N; n++) v[n*OB +: OB] = tbl[n][d[n*IB +: IB]];
        return v;
    endfunction

    // Call with inputs just driven after a posedge. Returns the acceptance edge.
    task automatic send_vec(input logic [SW-1:0] d, input logic [MW-1:0] e, output int acc);
        int n = 0;
        acc = -1;
        s_data  = d;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 300) begin
                fail_now("send_timeout");
                break;
            end
        end
        if (n <= 300) begin
            acc = cyc + 1;
            exp_q.push_back(e);
            acc_q.push_back(acc);
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic cfg_write(input int n, input int x, input int v, input bit update_model);
        cfg_we    = 1'b1;
        cfg_addr  = {IW'(n), IB'(x)};
        cfg_wdata = OB'(v);
        if (update_model) tbl[n][x] = OB'(v);
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || m_valid) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) fail_now("drain_timeout");
        @(posedge clk); #1;
    endtask

    // Monitor: compares every output vector against the scoreboard.
    initial begin : monitor
        logic          prev_v = 1'b0;
        logic          after_hs = 1'b0;
        logic [MW-1:0] held = '0;
        logic [MW-1:0] e;
        int            a;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v   = 1'b0;
                after_hs = 1'b0;
                continue;
            end
            if (after_hs) begin
                check("post_hs_m_valid", 64'(m_valid), 64'(0));
                check("post_hs_s_ready", 64'(s_ready), 64'(!cfg_we));
                after_hs = 1'b0;
            end
            if (m_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_m_valid");
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    check("m_data", 64'(m_data), 64'(e));
                    check("latency", 64'(cyc - a + 1), 64'(LAT));
                end
                held = m_data;
            end else if (m_valid) begin
                check("m_data_stable", 64'(m_data), 64'(held));
            end
            if (m_valid) check("out_s_ready", 64'(s_ready), 64'(0));
            if (m_valid && m_ready) begin
                hs_edge  = cyc + 1;
                after_hs = 1'b1;
            end
            prev_v = m_valid;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int acc1, acc2, k;

        // ---- Reset ----
        #2;
        check("rst_m_valid", 64'(m_valid), 64'(0));
        check("rst_m_data", 64'(m_data), 64'(0));
        check("rst_s_ready", 64'(s_ready), 64'(1));
        check("rst_cfg_busy", 64'(cfg_busy), 64'(0));
        cfg_we = 1'b1;
        #1;
        check("rst_s_ready_cfg", 64'(s_ready), 64'(0));
        cfg_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_s_ready", 64'(s_ready), 64'(1));
        check("rel_cfg_busy", 64'(cfg_busy), 64'(0));
        @(posedge clk); #1;

        // ---- Load table (n+x)&3 ----
        for (int n = 0; n < N; n++) begin
            for (int x = 0; x < (1 << IB); x++) begin
                cfg_we    = 1'b1;
                cfg_addr  = {IW'(n), IB'(x)};
                cfg_wdata = OB'((n + x) & 3);
                tbl[n][x] = OB'((n + x) & 3);
                @(posedge clk); #1;
            end
        end
        cfg_we = 1'b0;

        // ---- Basic lookup + back-to-back throughput ----
        m_ready = 1'b1;
        send_vec(vec_index(), exp_basic(), acc1);
        send_vec(vec_index(), exp_basic(), acc2);
        check("throughput", 64'(acc2 - acc1), 64'(N + 3));
        wait_drain();

        // ---- Backpressure with a second vector pending ----
        m_ready = 1'b0;
        fork
            begin
                logic [SW-1:0] v1, v2;
                for (int n = 0; n < N; n++) begin
                    v1[n*IB +: IB] = IB'(3 * n + 1);
                    v2[n*IB +: IB] = IB'(255 - 7 * n);
                end
                send_vec(v1, exp_model(v1), acc1);
                send_vec(v2, exp_model(v2), acc2);
                check("bp_accept_after_hs", 64'(acc2), 64'(hs_edge + 1));
            end
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!m_valid && k < 200);
                if (!m_valid) fail_now("bp_wait_m_valid");
                repeat (10) begin
                    check("bp_s_ready", 64'(s_ready), 64'(0));
                    check("bp_m_valid_held", 64'(m_valid), 64'(1));
                    @(negedge clk);
                end
                @(posedge clk); #1;
                m_ready = 1'b1;
            end
        join
        wait_drain();

        // ---- Config write during RUN is dropped ----
        cfg_write(5, 'h12, 1, 1'b1);
        fork
            begin
                logic [SW-1:0] v = '0;
                v[5*IB +: IB] = IB'('h12);
                send_vec(v, exp_model(v), acc1);
                wait_drain();
                send_vec(v, exp_model(v), acc1);
                check("busy_model_entry", 64'(tbl[5]['h12]), 64'(1));
            end
            begin
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (!cfg_busy && k < 200);
                @(posedge clk); #1;
                cfg_we    = 1'b1;
                cfg_addr  = {IW'(5), IB'('h12)};
                cfg_wdata = OB'(3);
                @(negedge clk);
                check("busy_cfg_busy", 64'(cfg_busy), 64'(1));
                check("busy_s_ready", 64'(s_ready), 64'(0));
                @(posedge clk); #1;
                cfg_we = 1'b0;
            end
        join
        wait_drain();

        // ---- Simultaneous config write and input in IDLE ----
        tbl[0][0] = OB'(2);
        cfg_we    = 1'b1;
        cfg_addr  = {IW'(0), IB'(0)};
        cfg_wdata = OB'(2);
        s_data    = '0;
        s_valid   = 1'b1;
        @(negedge clk);
        check("sim_s_ready", 64'(s_ready), 64'(0));
        k = cyc;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        send_vec('0, exp_model('0), acc1);
        check("sim_accept_next", 64'(acc1), 64'(k + 2));
        wait_drain();

        // ---- Reset mid-operation ----
        cfg_write(0, 0, 0, 1'b1);   // restore the basic table
        send_vec(vec_index(), exp_basic(), acc1);
        repeat (8) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 64'(m_valid), 64'(0));
        check("midrst_m_data", 64'(m_data), 64'(0));
        check("midrst_cfg_busy", 64'(cfg_busy), 64'(0));
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", 64'(cfg_busy), 64'(0));
        check("midrst_s_ready", 64'(s_ready), 64'(1));
        repeat (40) @(posedge clk);   // monitor flags any stray m_valid here
        #1;
        send_vec(vec_index(), exp_basic(), acc1);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lut_layer_scheduler.md
Name: lut_layer_scheduler

Overview:
- Time-multiplexes one shared LUT table memory across all neurons of a LogicNets layer instead of instantiating one ROM per neuron.
- Accepts a packed input activation vector over a valid/ready handshake and performs one table lookup per neuron, one neuron per cycle.
- Returns the packed output activation vector over a valid/ready handshake.
- Provides a configuration write port that loads neuron truth tables while the scheduler is idle.

Parameters:
- NUM_NEURONS, 32: neurons in the layer; must be at least 2.
- IN_BITS, 8: packed input bits per neuron (fan-in × input bitwidth); table depth per neuron is 2^IN_BITS.
- OUT_BITS, 2: output bits per neuron.
- IDX_W, $clog2(NUM_NEURONS): neuron index width; derived, not overridable.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input vector valid.
- s_ready  out  1  input vector accepted this cycle when s_valid is also high.
- s_data  in  NUM_NEURONS*IN_BITS  input vector; neuron n occupies bits [n*IN_BITS +: IN_BITS].
- m_valid  out  1  output vector valid.
- m_ready  in  1  downstream accepts the output vector.
- m_data  out  NUM_NEURONS*OUT_BITS  output vector; neuron n occupies bits [n*OUT_BITS +: OUT_BITS].
- cfg_we  in  1  table write strobe.
- cfg_addr  in  IDX_W+IN_BITS  table address {neuron_idx, input_pattern}.
- cfg_wdata  in  OUT_BITS  table entry value.
- cfg_busy  out  1  high whenever the state is not IDLE; writes issued while it is high are dropped.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state=IDLE, m_valid=0, m_data=0, neuron counter=0, input register=0.
  - cfg_busy=0; s_ready=1 unless cfg_we is high.
  - Table RAM contents are not reset; they persist across reset and are undefined after power-up.
- State IDLE:
  - s_ready = !cfg_we.
  - If cfg_we is high, the entry at cfg_addr is written at the clock edge. A write has priority over input acceptance in the same cycle.
  - If s_valid && s_ready, s_data is captured into the input register, counter=0, next state RUN.
- State RUN (cycles 1..NUM_NEURONS after acceptance):
  - Drives RAM read address {cnt, in_reg[cnt*IN_BITS +: IN_BITS]} and increments cnt.
  - When cnt == NUM_NEURONS-1, next state LAST.
- RAM read is synchronous with 1-cycle latency: rdata for the address issued in cycle c is written into the m_data slice for that neuron at the end of cycle c+1.
- State LAST (one cycle): captures the final neuron's rdata; next state OUT.
- State OUT:
  - m_valid=1; m_data held stable; s_ready=0.
  - On m_ready, m_valid drops at the next edge and the next state is IDLE.
- Latency: acceptance edge at cycle 0 → m_valid high from cycle NUM_NEURONS+2 (34 at default).
- Throughput: one vector per NUM_NEURONS+3 cycles when m_ready is held high.
- No look-ahead: s_ready is low in RUN, LAST and OUT.
- cfg_busy = (state != IDLE). cfg_we outside IDLE is ignored: no write and no error flag.
- m_data slices from the previous vector are overwritten progressively during RUN. m_data is only defined while m_valid is high.
- Counter wrap: cnt is IDX_W bits. With a non-power-of-2 NUM_NEURONS, the terminal compare at NUM_NEURONS-1 stops issue, so addresses ≥ NUM_NEURONS are never driven.
- Reset mid-operation (RUN, LAST or OUT): the transaction is aborted with no partial output, all registers return to reset values, and the RAM is untouched.
- Handshake: once asserted, m_valid stays high with m_data stable until m_ready is sampled high.

Decomposition:
- Shared package lut_sched_pkg:
  - State enum {IDLE, RUN, LAST, OUT}.
  - Localparam helpers for the table depth, NUM_NEURONS << IN_BITS.
- One sub-module, lut_table_ram:
  - Single port: write when we, synchronous read, 1-cycle read latency, no reset.
  - Marked for block/distributed RAM inference.
  - Width OUT_BITS, depth NUM_NEURONS*2^IN_BITS.
  - Scheduler drives the address from cfg_addr in IDLE and from the scheduling address in RUN.

Test Plan:
- Reset:
  - Stimulus: assert rst_n low, then release; cfg_we=0.
  - Response: m_valid=0, m_data=0, s_ready=1, cfg_busy=0.
- Basic lookup:
  - Stimulus: load entry (n,x)=(n+x)&3 for all n,x; send s_data with slice n = n; hold m_ready=1.
  - Response: m_valid rises exactly 34 cycles after acceptance; slice n = (2n)&3; one-cycle m_valid pulse; s_ready=1 again the following cycle.
- Backpressure:
  - Stimulus: m_ready=0 for 10 cycles after m_valid, with a second vector pending on s_valid.
  - Response: m_data stable and s_ready=0 throughout; second vector accepted the cycle after the handshake completes.
- Config during busy:
  - Stimulus: cfg_we for entry (5,0x12)=3 issued in RUN, with the entry previously 1.
  - Response: cfg_busy=1; the next lookup of neuron 5 with input 0x12 still returns 1.
- Simultaneous config and input in IDLE:
  - Stimulus: cfg_we writes (0,0x00)=2 and s_valid with all-zero s_data in the same cycle.
  - Response: s_ready=0 that cycle; vector accepted next cycle; m_data slice 0 = 2.
- Reset mid-operation:
  - Stimulus: rst_n low at cycle 10 of RUN, then release; send the basic-lookup vector again.
  - Response: no m_valid pulse from the aborted vector; state IDLE after release; new vector returns the same results as the basic-lookup test, proving RAM contents were preserved.
